// File: rtl/spi_rx_buffer.sv
// spi_rx_buffer: synchronizes the SPI slave rx_done and captures rx_data into a first-word-fall-through FIFO
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_data, rx_done    parallel word and frame-complete level from the SPI slave (sclk domain)
//   rd_en               consumer pop request
//   dout                head-of-FIFO word, valid while empty=0
//   empty, full, count  occupancy status
//   overflow, clr_ovf   sticky dropped-frame flag and its synchronous clear
module spi_rx_buffer #(
  parameter int WIDTH       = 12,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_done,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   seen_q;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [AW:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   cap, wr, rd;
  assign empty    = count_q == '0;
  assign full     = count_q == FULL_CNT;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = mem_q[rptr_q];
  // rx_data is sampled directly: the slave holds it stable until well after the synchronized edge arrives.
  // A full FIFO still accepts a capture when the same cycle pops, since the freed slot is the one written.
  always_comb begin
    cap     = sync_q[SYNC_STAGES-1] & ~seen_q;
    rd      = rd_en & ~empty;
    wr      = cap & (~full | rd_en);
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
    ovf_d   = (cap & full & ~rd_en) | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      seen_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_done};
      seen_q  <= sync_q[SYNC_STAGES-1];
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (wr) begin
        mem_q[wptr_q] <= rx_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (rd) rptr_q <= rptr_q + AW'(1);
    end
  end
endmodule

// File: tb/tb_spi_rx_buffer.sv
// tb_spi_rx_buffer: randomized self-checking bench for spi_rx_buffer against a queue-based FIFO model
module tb_spi_rx_buffer;
  localparam int W = 12;
  localparam int D = 8;
  logic clk = 0, rst_n = 1, rx_done = 0, rd_en = 0, clr_ovf = 0;
  logic [W-1:0] rx_data = '0, dout;
  logic empty, full, overflow;
  logic [3:0] count;
  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic m_ovf = 0;

  spi_rx_buffer dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {count, empty, full, overflow};

  function automatic logic [6:0] exp_vec();
    return {4'(q.size()), q.size() == 0, q.size() == D, m_ovf};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; rx_done = 0; rd_en = 0; clr_ovf = 0;
    q.delete(); m_ovf = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  // One frame: rx_done rises, capture lands two edges later; rd/clr are driven into that capture cycle.
  task automatic send(input logic [W-1:0] d, input logic rd, input logic clr);
    logic set;
    @(negedge clk);
    rx_data = d; rx_done = 1;
    repeat (2) @(negedge clk);
    rd_en = rd; clr_ovf = clr;
    @(negedge clk);
    rd_en = 0; clr_ovf = 0;
    set = (q.size() == D) && !rd;
    if (rd && q.size() != 0) void'(q.pop_front());
    if (q.size() < D) q.push_back(d);
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    @(negedge clk);
    rx_done = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr_ovf = 1;
    @(negedge clk);
    clr_ovf = 0;
    m_ovf = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_cmp++; if (obs !== 7'b0000_100) begin n_fail++; $display("FAIL reset_status: got %b expected %b", obs, 7'b0000_100); end
    n_cmp++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 000", dout); end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (obs !== 7'b0000_100) begin n_fail++; $display("FAIL post_reset_status: got %b expected %b", obs, 7'b0000_100); end
    n_cmp++; if (dout !== '0) begin n_fail++; $display("FAIL post_reset_dout: got %h expected 000", dout); end
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    rx_data = 12'hA5C; rx_done = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL single_early: got count=%0d empty=%b expected count=0 empty=1", count, empty); end
    @(negedge clk);
    n_cmp++; if (count !== 4'd1 || empty !== 1'b0 || dout !== 12'hA5C) begin n_fail++; $display("FAIL single_capture: got count=%0d empty=%b dout=%h expected 1 0 a5c", count, empty, dout); end
    repeat (19) @(negedge clk);
    n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_held_level: got count=%0d expected 1", count); end
    rx_done = 0;
    repeat (2) @(negedge clk);
    pop();
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL single_pop: got count=%0d empty=%b expected 0 1", count, empty); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      send(W'(i), 1'b0, 1'b0);
      n_cmp++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL fill_status[%0d]: got %b expected %b", i, obs, exp_vec()); end
      if (i == 8) begin
        n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full: got full=%b ovf=%b expected 1 0", full, overflow); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      n_cmp++; if (dout !== W'(i)) begin n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, dout, W'(i)); end
      pop();
    end
    n_cmp++; if (obs !== exp_vec() || empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b expected %b", obs, exp_vec()); end
  endtask

  task automatic test_full_rw();
    apply_reset();
    for (int i = 0; i < D; i++) send(W'($urandom), 1'b0, 1'b0);
    send(12'hFFF, 1'b1, 1'b0);
    n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw: got count=%0d ovf=%b expected 8 0", count, overflow); end
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (dout !== q[0]) begin n_fail++; $display("FAIL full_rw_data[%0d]: got %h expected %h", k, dout, q[0]); end
      if (k == 8) begin
        n_cmp++; if (dout !== 12'hFFF) begin n_fail++; $display("FAIL full_rw_last: got %h expected fff", dout); end
      end
      pop();
    end
  endtask

  task automatic test_empty_rw();
    apply_reset();
    send(12'h123, 1'b1, 1'b0);
    n_cmp++; if (count !== 4'd1 || dout !== 12'h123) begin n_fail++; $display("FAIL empty_rw: got count=%0d dout=%h expected 1 123", count, dout); end
    pop();
    pop();
    n_cmp++; if (obs !== 7'b0000_100) begin n_fail++; $display("FAIL empty_pop_ignored: got %b expected %b", obs, 7'b0000_100); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int f = 0; f < 20; f++) begin
      while (q.size() >= 3 || (q.size() != 0 && $urandom_range(1, 0) == 1)) begin
        n_cmp++; if (dout !== q[0]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", f, dout, q[0]); end
        pop();
      end
      send(W'($urandom), 1'b0, 1'b0);
      n_cmp++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL wrap_status[%0d]: got %b expected %b", f, obs, exp_vec()); end
    end
    while (q.size() != 0) begin
      n_cmp++; if (dout !== q[0]) begin n_fail++; $display("FAIL wrap_drain: got %h expected %h", dout, q[0]); end
      pop();
    end
    n_cmp++; if (overflow !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got ovf=%b empty=%b expected 0 1", overflow, empty); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 60; t++) begin
      int sel;
      sel = $urandom_range(9, 0);
      if (sel < 6) send(W'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) == 0));
      else if (sel < 9) pop();
      else clr_pulse();
      n_cmp++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_status[%0d]: got %b expected %b", t, obs, exp_vec()); end
      if (q.size() != 0) begin
        n_cmp++; if (dout !== q[0]) begin n_fail++; $display("FAIL random_data[%0d]: got %h expected %h", t, dout, q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 9; i++) send(W'(i), 1'b0, 1'b0);
    repeat (3) pop();
    n_cmp++; if (obs !== exp_vec() || count !== 4'd5 || overflow !== 1'b1) begin n_fail++; $display("FAIL mid_prep: got %b expected %b", obs, exp_vec()); end
    @(negedge clk);
    rx_data = 12'hABC; rx_done = 1;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    n_cmp++; if (obs !== 7'b0000_100 || dout !== '0) begin n_fail++; $display("FAIL mid_async_reset: got %b dout=%h expected %b dout=000", obs, dout, 7'b0000_100); end
    q.delete(); m_ovf = 0;
    rx_done = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    n_cmp++; if (obs !== 7'b0000_100) begin n_fail++; $display("FAIL mid_inflight_dropped: got %b expected %b", obs, 7'b0000_100); end
    @(negedge clk);
    rst_n = 0; rx_data = 12'h3C3; rx_done = 1;
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    n_cmp++; if (count !== 4'd1 || dout !== 12'h3C3) begin n_fail++; $display("FAIL high_at_release: got count=%0d dout=%h expected 1 3c3", count, dout); end
    rx_done = 0;
    q.push_back(12'h3C3);
    repeat (3) @(negedge clk);
    while (q.size() < D) send(W'($urandom), 1'b0, 1'b0);
    send(12'h555, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b1 || obs !== exp_vec()) begin n_fail++; $display("FAIL set_beats_clear: got %b expected %b", obs, exp_vec()); end
    clr_pulse();
    n_cmp++; if (overflow !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL clr_ovf: got ovf=%b count=%0d expected 0 8", overflow, count); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_rx_buffer.md
SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the received word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on rx_done (at least 2).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rx_data  input  WIDTH  parallel word from the SPI slave dout, stable for at least SYNC_STAGES+2 clk cycles after rx_done rises.
REQ-007 rx_done  input  1  frame-complete level from the SPI slave (sclk domain, asynchronous to clk).
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 dout  output  WIDTH  head-of-FIFO word (first-word-fall-through), valid while empty=0.
REQ-010 empty  output  1  FIFO holds zero entries.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: at least one frame was dropped.
REQ-014 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 rx_done SHALL pass through a SYNC_STAGES-deep flop chain; rx_data SHALL NOT be synchronized.
REQ-016 A one-cycle capture pulse SHALL be generated on a 0->1 transition of the synchronized rx_done; a level held high SHALL produce exactly one pulse.
REQ-017 With SYNC_STAGES=2, rx_done rising before clk edge N SHALL write rx_data into the FIFO at edge N+2, so empty and count reflect the write from edge N+2.
REQ-018 A capture with full=0 SHALL write rx_data at the write pointer, advance the pointer and increment count.
REQ-019 rd_en with empty=0 SHALL advance the read pointer and decrement count; dout SHALL present the next entry in the following cycle.
REQ-020 rd_en with empty=1 SHALL be ignored: no pointer or count change, no error flag.
REQ-021 A capture and an rd_en in the same cycle with 0<count<DEPTH SHALL perform both operations and leave count unchanged.
REQ-022 A capture and an rd_en in the same cycle with count=DEPTH SHALL perform both operations, leave count=DEPTH and leave overflow unchanged.
REQ-023 A capture and an rd_en in the same cycle with count=0 SHALL perform the write only; the pop is ignored.
REQ-024 A capture with full=1 and no rd_en SHALL discard rx_data, leave FIFO contents and pointers unchanged, and set overflow.
REQ-025 overflow SHALL stay set until clr_ovf=1; when set and clear occur in the same cycle, set SHALL win.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered-consistent with count in every cycle.
REQ-028 dout SHALL equal the storage entry at the read pointer; its value while empty=1 is don't-care except immediately after reset.

Reset
REQ-029 rst_n=0 SHALL asynchronously set both pointers, count, the synchronizer chain and the edge-detect flop to 0, set overflow to 0, and clear all storage entries to 0.
REQ-030 During and after reset: empty=1, full=0, count=0, overflow=0, dout=0.
REQ-031 If rx_done is high when rst_n deasserts, it SHALL be captured once after synchronization, as a rising edge from the reset value 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored words and any in-flight capture.

Verification
REQ-033 Single frame: rx_data=12'hA5C, pulse rx_done high for 22 clk -> at edge N+2 empty=0, count=1, dout=12'hA5C; one rd_en -> empty=1, count=0.
REQ-034 Fill and overflow: 9 frames carrying 12'h001..12'h009, no reads -> full=1 after the 8th frame, overflow=1 after the 9th; 8 pops return 12'h001..12'h008 in order, 12'h009 is absent.
REQ-035 Full with simultaneous read/write: count=8, capture 12'hFFF coincident with rd_en -> count stays 8, overflow=0, 12'hFFF emerges as the 8th subsequent pop.
REQ-036 Empty with simultaneous read/write: count=0, capture 12'h123 with rd_en=1 -> count=1, dout=12'h123; rd_en on empty FIFO -> no change.
REQ-037 Wrap-around: 20 frames interleaved with pops keeping count<=3 -> data order preserved across pointer wrap, overflow=0.
REQ-038 Reset mid-stream: 5 words stored, overflow=1, assert rst_n=0 asynchronously between clk edges -> outputs immediately count=0, empty=1, overflow=0, dout=0; clr_ovf coincident with an overflow event leaves overflow=1.
